// File: rtl/turn_signal_pkg.sv
// Shared mode encoding, frame length and request arbitration for the turn-signal front end.
// Pure definitions: no latency, no backpressure.
package turn_signal_pkg;

   localparam logic [1:0] MODE_IDLE   = 2'd0;
   localparam logic [1:0] MODE_LEFT   = 2'd1;
   localparam logic [1:0] MODE_RIGHT  = 2'd2;
   localparam logic [1:0] MODE_HAZARD = 2'd3;

   localparam int FRAME_STEPS = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = MODE_IDLE,
      ST_LEFT   = MODE_LEFT,
      ST_RIGHT  = MODE_RIGHT,
      ST_HAZARD = MODE_HAZARD
   } mode_e;

   // Both sides requested together is treated as a hazard request.
   function automatic mode_e decode_req(input logic left, input logic right, input logic hazard);
      mode_e req;
      if (hazard || (left && right)) req = ST_HAZARD;
      else if (left)                 req = ST_LEFT;
      else if (right)                req = ST_RIGHT;
      else                           req = ST_IDLE;
      return req;
   endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus stability counter for one bouncy switch.
// Latency 2 + DEBOUNCE_CNT clk from raw edge to debounced edge; no backpressure.
module switch_debouncer #(
   parameter int DEBOUNCE_CNT = 16
) (
   input  logic clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_deb
);

   localparam int CW = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_deb;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_deb <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
         if (r_s2 == r_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            // Differed for DEBOUNCE_CNT consecutive samples: accept the new level.
            r_deb <= ~r_deb;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_deb = r_deb;

endmodule

// File: rtl/turn_signal_input_ctrl.sv
// Debounces the turn switches, paces the lamp sequence with a step tick and commits mode changes at frame ends.
// Mode takes effect on the first step after the debounced request, or at frame end when flashing; no backpressure.
module turn_signal_input_ctrl
   import turn_signal_pkg::*;
#(
   parameter int DEBOUNCE_CNT = 16,
   parameter int STEP_DIV     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       left_sw,
   input  logic       right_sw,
   input  logic       hazard_sw,
   output logic       step,
   output logic       left_en,
   output logic       right_en,
   output logic [1:0] phase,
   output logic [1:0] mode
);

   localparam int PW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST   = PW'(STEP_DIV - 1);
   localparam logic [1:0]    PHASE_LAST = 2'(FRAME_STEPS - 1);

   logic          w_left_deb;
   logic          w_right_deb;
   logic          w_hazard_deb;
   mode_e         w_req;
   logic [PW-1:0] w_pre_nxt;

   logic [PW-1:0] r_pre;
   logic          r_step;
   mode_e         r_mode;
   logic [1:0]    r_phase;
   logic          r_left_en;
   logic          r_right_en;

   switch_debouncer #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_deb_left (
      .clk     (clk),
      .i_rst_n (reset),
      .i_raw   (left_sw),
      .o_deb   (w_left_deb)
   );

   switch_debouncer #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_deb_right (
      .clk     (clk),
      .i_rst_n (reset),
      .i_raw   (right_sw),
      .o_deb   (w_right_deb)
   );

   switch_debouncer #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_deb_hazard (
      .clk     (clk),
      .i_rst_n (reset),
      .i_raw   (hazard_sw),
      .o_deb   (w_hazard_deb)
   );

   assign w_req     = decode_req(w_left_deb, w_right_deb, w_hazard_deb);
   assign w_pre_nxt = (r_pre == PRE_LAST) ? '0 : r_pre + PW'(1);

   // step is registered so it is high exactly while the prescaler sits at its last count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pre  <= '0;
         r_step <= 1'b0;
      end else begin
         r_pre  <= w_pre_nxt;
         r_step <= (w_pre_nxt == PRE_LAST);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mode     <= ST_IDLE;
         r_phase    <= 2'd0;
         r_left_en  <= 1'b0;
         r_right_en <= 1'b0;
      end else if (r_step) begin
         if (r_mode == ST_IDLE || r_phase == PHASE_LAST) begin
            // Frame boundary (or idle): the only point where a new request is committed.
            r_mode     <= w_req;
            r_phase    <= 2'd0;
            r_left_en  <= (w_req == ST_LEFT)  || (w_req == ST_HAZARD);
            r_right_en <= (w_req == ST_RIGHT) || (w_req == ST_HAZARD);
         end else begin
            r_phase <= r_phase + 2'd1;
         end
      end
   end

   assign step     = r_step;
   assign left_en  = r_left_en;
   assign right_en = r_right_en;
   assign phase    = r_phase;
   assign mode     = r_mode;

endmodule

// File: tb/tb_turn_signal_input_ctrl.sv
// Directed bench for turn_signal_input_ctrl with a cycle-level behavioural model and per-cycle compare.
module tb_turn_signal_input_ctrl;

   localparam int DB = 4;
   localparam int SD = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       left_sw = 1'b0;
   logic       right_sw = 1'b0;
   logic       hazard_sw = 1'b0;
   logic       step;
   logic       left_en;
   logic       right_en;
   logic [1:0] phase;
   logic [1:0] mode;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   turn_signal_input_ctrl #(.DEBOUNCE_CNT(DB), .STEP_DIV(SD)) dut (
      .clk       (clk),
      .reset     (reset),
      .left_sw   (left_sw),
      .right_sw  (right_sw),
      .hazard_sw (hazard_sw),
      .step      (step),
      .left_en   (left_en),
      .right_en  (right_en),
      .phase     (phase),
      .mode      (mode)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_n counts clock edges since reset release; a step event happens on every SD-th edge.
   int m_n;
   int m_mode;
   int m_phase;
   bit m_deb [3];
   bit raw_hist [3][2];
   bit syn_hist [3][DB];
   bit cur [3];
   bit syn;
   bit all_diff;

   function automatic int req_of(input bit l, input bit r, input bit h);
      if (h || (l && r)) return 3;
      if (l) return 1;
      if (r) return 2;
      return 0;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_n = 0;
         m_mode = 0;
         m_phase = 0;
         for (int s = 0; s < 3; s++) begin
            m_deb[s] = 1'b0;
            raw_hist[s][0] = 1'b0;
            raw_hist[s][1] = 1'b0;
            for (int i = 0; i < DB; i++) syn_hist[s][i] = 1'b0;
         end
      end else begin
         cur[0] = left_sw;
         cur[1] = right_sw;
         cur[2] = hazard_sw;
         m_n = m_n + 1;
         if (m_n % SD == 0) begin
            if (m_mode == 0 || m_phase == 3) begin
               m_mode  = req_of(m_deb[0], m_deb[1], m_deb[2]);
               m_phase = 0;
            end else begin
               m_phase = m_phase + 1;
            end
         end
         for (int s = 0; s < 3; s++) begin
            syn = raw_hist[s][1];
            raw_hist[s][1] = raw_hist[s][0];
            raw_hist[s][0] = cur[s];
            for (int i = DB - 1; i > 0; i--) syn_hist[s][i] = syn_hist[s][i-1];
            syn_hist[s][0] = syn;
            all_diff = 1'b1;
            for (int i = 0; i < DB; i++) if (syn_hist[s][i] == m_deb[s]) all_diff = 1'b0;
            if (all_diff) m_deb[s] = !m_deb[s];
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("step",     step,     (m_n % SD == SD - 1));
         check("mode",     mode,     m_mode);
         check("phase",    phase,    m_phase);
         check("left_en",  left_en,  (m_mode == 1 || m_mode == 3));
         check("right_en", right_en, (m_mode == 2 || m_mode == 3));
      end
   end

   // ---------------- bounded waits ----------------
   task automatic wait_mode(input int m, input int limit, output int cyc);
      cyc = 0;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (mode == 2'(m)) begin
            cyc = i;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL wait_mode: timeout waiting for mode %0d, mode is %0d", m, mode);
   endtask

   task automatic wait_phase(input int p, input int limit);
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (phase == 2'(p)) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_phase: timeout waiting for phase %0d, phase is %0d", p, phase);
   endtask

   int cyc;
   int nsteps;
   int first;
   int exp_ph [4] = '{1, 2, 3, 0};

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      check("rst_step", step, 0);
      check("rst_mode", mode, 0);
      check("rst_phase", phase, 0);
      check("rst_en", {left_en, right_en}, 0);
      reset = 1'b1;

      // Idle: steps after edges 7,15,23,31 -> events at clk 8,16,24,32
      nsteps = 0;
      first = 0;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         if (step) begin
            nsteps++;
            if (first == 0) first = i;
         end
      end
      check("idle_steps", nsteps, 4);
      check("idle_first_step", first, 7);

      // Left held: debounced at edge 38, committed at step edge 40
      left_sw = 1'b1;
      wait_mode(1, 40, cyc);
      check("left_latency", cyc, 8);
      check("left_en_on", left_en, 1);
      for (int k = 0; k < 4; k++) begin
         repeat (SD) @(negedge clk);
         check("left_phase_seq", phase, exp_ph[k]);
      end

      // Right added mid-frame: held off until frame end
      wait_phase(1, 40);
      right_sw = 1'b1;
      wait_phase(3, 40);
      check("lr_hold_mode", mode, 1);
      wait_phase(0, 40);
      check("lr_hazard_mode", mode, 3);
      check("lr_both_en", {left_en, right_en}, 2'b11);

      // Release both, back to idle
      left_sw = 1'b0;
      right_sw = 1'b0;
      wait_mode(0, 100, cyc);

      // Bounce 1-0-1-0 at 2 clk per level: never accepted
      for (int k = 0; k < 4; k++) begin
         left_sw = ~left_sw;
         repeat (2) @(negedge clk);
      end
      repeat (40) @(negedge clk);
      check("bounce_mode", mode, 0);
      check("bounce_left_en", left_en, 0);

      // Hazard dropped at phase 2: frame completes, then idle
      hazard_sw = 1'b1;
      wait_mode(3, 40, cyc);
      wait_phase(2, 40);
      hazard_sw = 1'b0;
      wait_phase(3, 40);
      check("haz_finish_mode", mode, 3);
      wait_mode(0, 40, cyc);
      check("haz_exit_latency", cyc, SD);
      check("haz_exit_phase", phase, 0);

      // Async reset in LEFT at phase 2
      left_sw = 1'b1;
      wait_mode(1, 40, cyc);
      wait_phase(2, 40);
      left_sw = 1'b0;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("arst_mode", mode, 0);
      check("arst_phase", phase, 0);
      check("arst_en", {left_en, right_en}, 0);
      check("arst_step", step, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (step && first == 0) first = i;
      end
      check("arst_first_step", first, 7);

      repeat (4) @(negedge clk);
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
